// File: rtl/demux_pkg.sv
// Shared definitions for the AXIS demux frame scheduler: destination modes and FSM states.
package demux_pkg;

    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_RR    = 2'd1;
    localparam logic [1:0] MODE_WRR   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GAP   = 2'd2
    } sched_state_e;

endpackage

// File: rtl/demux_wrr_credit.sv
// Credit counter and next-destination decision, applied when the scheduler leaves GAP.
module demux_wrr_credit
    import demux_pkg::*;
#(
    parameter int WEIGHT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sel,
    input  logic [1:0]          mode,
    input  logic                dest,
    input  logic [WEIGHT_W-1:0] w0,
    input  logic [WEIGHT_W-1:0] w1,
    input  logic                advance,
    output logic                next_sel
);

    logic [WEIGHT_W-1:0] credit;
    logic [WEIGHT_W-1:0] w_cur;
    logic                spent;

    assign w_cur = sel ? w1 : w0;
    // >= so that a weight lowered below the running credit still forces a switch
    assign spent = (credit >= w_cur);

    always_comb begin
        next_sel = dest;
        case (mode)
            MODE_RR:  next_sel = ~sel;
            MODE_WRR: next_sel = spent ? ~sel : sel;
            default:  next_sel = dest;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit <= '0;
        end else if (mode != MODE_WRR) begin
            credit <= '0;
        end else if (advance) begin
            credit <= spent ? '0 : credit + WEIGHT_W'(1);
        end
    end

endmodule

// File: rtl/demux_frame_sched.sv
// Frame-aware select scheduler for the AXIS 1:2 demux; switches sel only between frames
// and holds off the source for a drain gap after every frame.
//   state | meaning
//   IDLE  | no frame open; fixed mode lets sel track cfg_dest
//   FRAME | frame in flight; sel and config frozen
//   GAP   | drain gap, hold asserted; sel reloaded on the last cycle
module demux_frame_sched
    import demux_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int WEIGHT_W   = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_axis_tvalid,
    input  logic                s_axis_tready,
    input  logic                s_axis_tlast,
    input  logic [1:0]          cfg_mode,
    input  logic                cfg_dest,
    input  logic [WEIGHT_W-1:0] cfg_w0,
    input  logic [WEIGHT_W-1:0] cfg_w1,
    output logic                sel,
    output logic                hold,
    output logic                busy,
    output logic [CNT_W-1:0]    frames0,
    output logic [CNT_W-1:0]    frames1,
    output logic                err
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    sched_state_e     state;
    logic [GAP_W-1:0] gap_cnt;
    logic             beat;
    logic             last_beat;
    logic             gap_done;
    logic             fixed_mode;
    logic             next_sel;

    assign beat       = s_axis_tvalid & s_axis_tready;
    assign last_beat  = beat & s_axis_tlast;
    assign gap_done   = (state == GAP) && (gap_cnt == '0);
    assign fixed_mode = (cfg_mode != MODE_RR) && (cfg_mode != MODE_WRR);

    demux_wrr_credit #(
        .WEIGHT_W (WEIGHT_W)
    ) u_credit (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .mode     (cfg_mode),
        .dest     (cfg_dest),
        .w0       (cfg_w0),
        .w1       (cfg_w1),
        .advance  (gap_done),
        .next_sel (next_sel)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            gap_cnt <= '0;
            sel     <= 1'b0;
            hold    <= 1'b0;
            busy    <= 1'b0;
            frames0 <= '0;
            frames1 <= '0;
            err     <= 1'b0;
        end else begin
            if (beat && hold)
                err <= 1'b1;

            // last beats are counted in every state, including stray ones during GAP
            if (last_beat) begin
                if (sel)
                    frames1 <= frames1 + CNT_W'(1);
                else
                    frames0 <= frames0 + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (last_beat) begin
                        state   <= GAP;
                        hold    <= 1'b1;
                        busy    <= 1'b1;
                        gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                    end else if (beat) begin
                        state <= FRAME;
                        busy  <= 1'b1;
                    end else if (fixed_mode) begin
                        sel <= cfg_dest;
                    end
                end
                FRAME: begin
                    if (last_beat) begin
                        state   <= GAP;
                        hold    <= 1'b1;
                        gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                        hold  <= 1'b0;
                        busy  <= 1'b0;
                        sel   <= next_sel;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    hold  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_frame_sched.sv
// Directed bench for demux_frame_sched: table of frames with expected sel/counters,
// plus hand-written sequences for config timing, err, reset and counter wrap.
module tb_demux_frame_sched;

    localparam int GAP   = 2;
    localparam int WW    = 4;
    // narrow counters keep the wrap sequence short
    localparam int CNT_W = 8;
    localparam int NVEC  = 11;

    logic             clk;
    logic             rst_n;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic             s_axis_tlast;
    logic [1:0]       cfg_mode;
    logic             cfg_dest;
    logic [WW-1:0]    cfg_w0;
    logic [WW-1:0]    cfg_w1;
    logic             sel;
    logic             hold;
    logic             busy;
    logic [CNT_W-1:0] frames0;
    logic [CNT_W-1:0] frames1;
    logic             err;

    int errors = 0;
    int checks = 0;

    demux_frame_sched #(
        .GAP_CYCLES (GAP),
        .WEIGHT_W   (WW),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .cfg_mode      (cfg_mode),
        .cfg_dest      (cfg_dest),
        .cfg_w0        (cfg_w0),
        .cfg_w1        (cfg_w1),
        .sel           (sel),
        .hold          (hold),
        .busy          (busy),
        .frames0       (frames0),
        .frames1       (frames1),
        .err           (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit         rst;
        logic [1:0] mode;
        logic [3:0] w0;
        logic [3:0] w1;
        logic       dest;
        int         nbeats;
        logic       exp_sel;
        int         exp_f0;
        int         exp_f1;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // called at a negedge; returns at the negedge after the beat's edge
    task automatic beat(input logic last);
        s_axis_tvalid = 1'b1;
        s_axis_tready = 1'b1;
        s_axis_tlast  = last;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_gap();
        repeat (GAP) @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        s_axis_tlast  = 1'b0;
        cfg_mode      = 2'd0;
        cfg_dest      = 1'b0;
        cfg_w0        = '0;
        cfg_w1        = '0;

        //          rst  mode  w0    w1    dest  n  sel   f0 f1
        vecs[0]  = '{1'b1, 2'd1, 4'd0, 4'd0, 1'b0, 4, 1'b0, 1, 0};
        vecs[1]  = '{1'b0, 2'd1, 4'd0, 4'd0, 1'b0, 4, 1'b1, 1, 1};
        vecs[2]  = '{1'b0, 2'd1, 4'd0, 4'd0, 1'b0, 4, 1'b0, 2, 1};
        vecs[3]  = '{1'b1, 2'd2, 4'd2, 4'd0, 1'b0, 1, 1'b0, 1, 0};
        vecs[4]  = '{1'b0, 2'd2, 4'd2, 4'd0, 1'b0, 1, 1'b0, 2, 0};
        vecs[5]  = '{1'b0, 2'd2, 4'd2, 4'd0, 1'b0, 1, 1'b0, 3, 0};
        vecs[6]  = '{1'b0, 2'd2, 4'd2, 4'd0, 1'b0, 1, 1'b1, 3, 1};
        vecs[7]  = '{1'b0, 2'd2, 4'd2, 4'd0, 1'b0, 1, 1'b0, 4, 1};
        vecs[8]  = '{1'b0, 2'd2, 4'd2, 4'd0, 1'b0, 1, 1'b0, 5, 1};
        vecs[9]  = '{1'b1, 2'd0, 4'd0, 4'd0, 1'b1, 2, 1'b1, 0, 1};
        vecs[10] = '{1'b0, 2'd3, 4'd0, 4'd0, 1'b0, 3, 1'b0, 1, 1};

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_sel",     32'(sel),     32'd0);
        check("rst_hold",    32'(hold),    32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_frames0", 32'(frames0), 32'd0);
        check("rst_frames1", 32'(frames1), 32'd0);
        check("rst_err",     32'(err),     32'd0);

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].rst) do_reset();
            cfg_mode = vecs[i].mode;
            cfg_w0   = vecs[i].w0;
            cfg_w1   = vecs[i].w1;
            cfg_dest = vecs[i].dest;
            @(negedge clk);
            check($sformatf("v%0d_sel", i), 32'(sel), 32'(vecs[i].exp_sel));
            for (int b = 0; b < vecs[i].nbeats; b++)
                beat(b == vecs[i].nbeats - 1);
            for (int g = 0; g < GAP; g++) begin
                check($sformatf("v%0d_gap%0d_hold", i, g), 32'(hold), 32'd1);
                check($sformatf("v%0d_gap%0d_busy", i, g), 32'(busy), 32'd1);
                check($sformatf("v%0d_gap%0d_sel", i, g), 32'(sel), 32'(vecs[i].exp_sel));
                @(negedge clk);
            end
            check($sformatf("v%0d_hold_end", i), 32'(hold), 32'd0);
            check($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_frames0", i), 32'(frames0), 32'(vecs[i].exp_f0));
            check($sformatf("v%0d_frames1", i), 32'(frames1), 32'(vecs[i].exp_f1));
        end

        // fixed mode: cfg_dest change mid-frame waits for GAP exit; in IDLE it follows next cycle
        do_reset();
        cfg_mode = 2'd0;
        cfg_dest = 1'b0;
        @(negedge clk);
        beat(1'b0);
        cfg_dest = 1'b1;
        beat(1'b0);
        check("fix_mid_sel", 32'(sel), 32'd0);
        beat(1'b1);
        check("fix_gap0_sel", 32'(sel), 32'd0);
        @(negedge clk);
        check("fix_gap1_sel", 32'(sel), 32'd0);
        @(negedge clk);
        check("fix_exit_sel", 32'(sel), 32'd1);
        check("fix_exit_hold", 32'(hold), 32'd0);
        cfg_dest = 1'b0;
        @(negedge clk);
        check("fix_idle_sel", 32'(sel), 32'd0);

        // mode sampled at GAP exit, not at the last beat
        do_reset();
        cfg_mode = 2'd0;
        cfg_dest = 1'b0;
        @(negedge clk);
        beat(1'b1);
        cfg_mode = 2'd1;
        wait_gap();
        check("mode_at_exit_sel", 32'(sel), 32'd1);

        // weight lowered below running credit during a frame forces the switch
        do_reset();
        cfg_mode = 2'd2;
        cfg_w0   = 4'd3;
        cfg_w1   = 4'd0;
        @(negedge clk);
        beat(1'b1);
        wait_gap();
        beat(1'b1);
        wait_gap();
        check("wchg_pre_sel", 32'(sel), 32'd0);
        beat(1'b0);
        cfg_w0 = 4'd1;
        beat(1'b1);
        wait_gap();
        check("wchg_sel", 32'(sel), 32'd1);
        check("wchg_frames0", 32'(frames0), 32'd3);

        // beat while hold is high sets sticky err; stray last beat still counted
        do_reset();
        cfg_mode = 2'd1;
        @(negedge clk);
        beat(1'b1);
        check("err_pre", 32'(err), 32'd0);
        beat(1'b1);
        check("err_set", 32'(err), 32'd1);
        check("err_frames0", 32'(frames0), 32'd2);
        repeat (5) @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);
        check("err_rr_sel", 32'(sel), 32'd1);
        do_reset();
        check("err_cleared", 32'(err), 32'd0);

        // reset mid-GAP aborts the gap and the pending select change
        do_reset();
        cfg_mode = 2'd1;
        @(negedge clk);
        beat(1'b1);
        check("rgap_busy_pre", 32'(busy), 32'd1);
        do_reset();
        check("rgap_sel", 32'(sel), 32'd0);
        check("rgap_hold", 32'(hold), 32'd0);
        check("rgap_busy", 32'(busy), 32'd0);
        check("rgap_frames0", 32'(frames0), 32'd0);
        repeat (3) @(negedge clk);
        check("rgap_idle_sel", 32'(sel), 32'd0);
        check("rgap_idle_hold", 32'(hold), 32'd0);

        // frames1 wrap from all-ones to zero
        do_reset();
        cfg_mode = 2'd0;
        cfg_dest = 1'b1;
        @(negedge clk);
        for (int f = 0; f < (1 << CNT_W) - 1; f++) begin
            beat(1'b1);
            wait_gap();
        end
        check("wrap_full", 32'(frames1), 32'((1 << CNT_W) - 1));
        beat(1'b1);
        wait_gap();
        check("wrap_zero", 32'(frames1), 32'd0);
        check("wrap_frames0", 32'(frames0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
